cond_logic_pipe: RTL and testbench
==================================

COND_LOGIC_PIPE -- requirements
Module: cond_logic_pipe

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports ValidE input 1 (E-stage instruction valid), StallE input 1 (E stage holds), FlushE input 1 (E instruction killed).
REQ-004 SHALL have ports CondE input 4 (ARM cond field), FlagWE input 2 (bit1 = write N,Z; bit0 = write C,V), ALUFlags input 4 ({N,Z,C,V} from ALU).
REQ-005 SHALL have ports PCSE, RegWE, MemWE, NoWriteE, each input 1 (unconditional decode controls).
REQ-006 SHALL have port CntClr input 1 (synchronous clear of squash counter).
REQ-007 SHALL have ports CondExE, PCSrcE, each output 1 (combinational E-stage results).
REQ-008 SHALL have ports ValidM, PCSrcM, RegWriteM, MemWriteM, each output 1 (registered M-stage controls).
REQ-009 SHALL have ports Flags output 4 (architectural {N,Z,C,V}) and SquashCnt output 16.

Function
REQ-010 SHALL decode CondEx from CondE against registered Flags, with ge = (N==V): 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~(C&~Z); 1010 ge; 1011 ~ge; 1100 ~Z&ge; 1101 ~(~Z&ge); 1110 1.
REQ-011 SHALL drive CondEx = 0 for CondE = 1111 (never X).
REQ-012 SHALL define adv = ValidE & ~StallE & ~FlushE; FlushE takes priority over StallE.
REQ-013 SHALL drive CondExE = CondEx & ValidE & ~FlushE, and PCSrcE = PCSE & CondExE.
REQ-014 SHALL update Flags[3:2] from ALUFlags[3:2] on a clock edge iff adv & CondEx & FlagWE[1].
REQ-015 SHALL update Flags[1:0] from ALUFlags[1:0] on a clock edge iff adv & CondEx & FlagWE[0]; otherwise the affected bits hold.
REQ-016 SHALL evaluate the condition against pre-update Flags; an instruction's own flag write is visible to the next instruction only (1-cycle latency).
REQ-017 SHALL on each edge with adv=1 load ValidM=1, PCSrcM=PCSE&CondEx, RegWriteM=RegWE&CondEx&~NoWriteE, MemWriteM=MemWE&CondEx.
REQ-018 SHALL on each edge with adv=0 load a bubble: ValidM=0, PCSrcM=0, RegWriteM=0, MemWriteM=0.
REQ-019 SHALL increment SquashCnt by 1 on each edge with adv & ~CondEx, saturating at 16'hFFFF.
REQ-020 SHALL clear SquashCnt to 0 on an edge with CntClr=1; clear wins over simultaneous increment.
REQ-021 SHALL not update Flags, M-stage outputs, or SquashCnt from a stalled instruction more than once: a held instruction takes effect only on the edge where it advances.

Reset
REQ-022 SHALL, while reset=0, asynchronously force Flags=4'b0000, SquashCnt=0, ValidM=0, PCSrcM=0, RegWriteM=0, MemWriteM=0.
REQ-023 SHALL resume normal operation on the first rising edge after reset deasserts; reset asserted mid-stall discards the held instruction's pending effects.
REQ-024 SHALL drive combinational outputs from reset-state Flags during reset (e.g. CondE=0001 gives CondExE=ValidE&~FlushE).

Verification
REQ-025 SHALL cover: reset; ValidE=1, CondE=1110, FlagWE=11, ALUFlags=0100 -> next cycle Flags=0100, ValidM=1; then CondE=0000 -> CondExE=1.
REQ-026 SHALL cover: Flags=0100, CondE=0001, RegWE=1, MemWE=1, FlagWE=11 -> RegWriteM=0, MemWriteM=0, Flags unchanged, SquashCnt +1.
REQ-027 SHALL cover: FlagWE=10, ALUFlags=1011 from Flags=0000 -> Flags=1000 (C,V held); then CondE=1011 -> CondExE=1 (N!=V).
REQ-028 SHALL cover: StallE=1 for 3 cycles with a failing cond -> ValidM=0 each cycle, SquashCnt +1 once after release; StallE=1 with FlushE=1 -> no update, bubble.
REQ-029 SHALL cover: SquashCnt preloaded to 16'hFFFF by 65535 squashes -> one more squash holds FFFF; CntClr=1 with simultaneous squash -> 0.
REQ-030 SHALL cover: CondE=1111 with PCSE=1 -> CondExE=0, PCSrcE=0, PCSrcM=0 next cycle; reset=0 mid-operation -> all registered outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cond_logic_pipe.sv
// ARM-style conditional execution logic for the E stage,
// with architectural flags, E->M control register and squash counter.
module cond_logic_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        ValidE,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic [3:0]  CondE,
    input  logic [1:0]  FlagWE,
    input  logic [3:0]  ALUFlags,
    input  logic        PCSE,
    input  logic        RegWE,
    input  logic        MemWE,
    input  logic        NoWriteE,
    input  logic        CntClr,
    output logic        CondExE,
    output logic        PCSrcE,
    output logic        ValidM,
    output logic        PCSrcM,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [3:0]  Flags,
    output logic [15:0] SquashCnt
);

    logic        cond_ex;
    logic        adv;
    logic        n_f, z_f, c_f, v_f, ge;

    logic [3:0]  flags_q, flags_d;
    logic [15:0] sq_q, sq_d;
    logic        valid_m_q, valid_m_d;
    logic        pcsrc_m_q, pcsrc_m_d;
    logic        regw_m_q, regw_m_d;
    logic        memw_m_q, memw_m_d;

    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign ge = (n_f == v_f);

    // Evaluate the cond field against the flags as they stand before this
    // instruction's own write; 1111 is treated as never-execute.
    always_comb begin
        cond_ex = 1'b0;
        case (CondE)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~(c_f & ~z_f);
            4'b1010: cond_ex = ge;
            4'b1011: cond_ex = ~ge;
            4'b1100: cond_ex = ~z_f & ge;
            4'b1101: cond_ex = ~(~z_f & ge);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // A held or killed instruction never advances; flush beats stall.
    assign adv     = ValidE & ~StallE & ~FlushE;
    assign CondExE = cond_ex & ValidE & ~FlushE;
    assign PCSrcE  = PCSE & CondExE;

    // Next-state: flags, M-stage controls and saturating squash counter.
    always_comb begin
        flags_d = flags_q;
        if (adv & cond_ex & FlagWE[1])
            flags_d[3:2] = ALUFlags[3:2];
        if (adv & cond_ex & FlagWE[0])
            flags_d[1:0] = ALUFlags[1:0];

        valid_m_d = adv;
        pcsrc_m_d = adv & PCSE & cond_ex;
        regw_m_d  = adv & RegWE & cond_ex & ~NoWriteE;
        memw_m_d  = adv & MemWE & cond_ex;

        sq_d = sq_q;
        if (CntClr)
            sq_d = 16'h0000;
        else if (adv & ~cond_ex & (sq_q != 16'hFFFF))
            sq_d = sq_q + 16'h0001;
    end

    // State registers, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q   <= 4'b0000;
            sq_q      <= 16'h0000;
            valid_m_q <= 1'b0;
            pcsrc_m_q <= 1'b0;
            regw_m_q  <= 1'b0;
            memw_m_q  <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            sq_q      <= sq_d;
            valid_m_q <= valid_m_d;
            pcsrc_m_q <= pcsrc_m_d;
            regw_m_q  <= regw_m_d;
            memw_m_q  <= memw_m_d;
        end
    end

    assign Flags     = flags_q;
    assign SquashCnt = sq_q;
    assign ValidM    = valid_m_q;
    assign PCSrcM    = pcsrc_m_q;
    assign RegWriteM = regw_m_q;
    assign MemWriteM = memw_m_q;

endmodule

// File: tb/tb_cond_logic_pipe.sv
// Testbench for cond_logic_pipe: vector table, directed corner
// sequences and randomized run against a behavioural model.
module tb_cond_logic_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidE, StallE, FlushE;
    logic [3:0]  CondE;
    logic [1:0]  FlagWE;
    logic [3:0]  ALUFlags;
    logic        PCSE, RegWE, MemWE, NoWriteE, CntClr;
    logic        CondExE, PCSrcE;
    logic        ValidM, PCSrcM, RegWriteM, MemWriteM;
    logic [3:0]  Flags;
    logic [15:0] SquashCnt;

    cond_logic_pipe dut (
        .clk(clk), .reset(reset),
        .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .FlagWE(FlagWE), .ALUFlags(ALUFlags),
        .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE),
        .NoWriteE(NoWriteE), .CntClr(CntClr),
        .CondExE(CondExE), .PCSrcE(PCSrcE),
        .ValidM(ValidM), .PCSrcM(PCSrcM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .Flags(Flags), .SquashCnt(SquashCnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---- behavioural model ----
    bit mn, mz, mc, mv;
    int msq;
    bit mvm, mpm, mrm, mmm;

    // Odd cond codes are the negation of the preceding even code.
    function automatic bit cond_true(logic [3:0] c, bit n, bit z, bit cf, bit v);
        bit b;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: return (c == 4'b1110);
        endcase
        return b ^ c[0];
    endfunction

    task automatic model_reset();
        {mn, mz, mc, mv} = 4'b0000;
        msq = 0;
        {mvm, mpm, mrm, mmm} = 4'b0000;
    endtask

    task automatic model_edge();
        bit adv, ok;
        adv = ValidE && !StallE && !FlushE;
        ok  = cond_true(CondE, mn, mz, mc, mv);
        if (adv && ok && FlagWE[1]) begin
            mn = ALUFlags[3];
            mz = ALUFlags[2];
        end
        if (adv && ok && FlagWE[0]) begin
            mc = ALUFlags[1];
            mv = ALUFlags[0];
        end
        mvm = adv;
        mpm = adv && ok && PCSE;
        mrm = adv && ok && RegWE && !NoWriteE;
        mmm = adv && ok && MemWE;
        if (CntClr) msq = 0;
        else if (adv && !ok) msq = (msq >= 65535) ? 65535 : msq + 1;
    endtask

    task automatic idle();
        ValidE = 0; StallE = 0; FlushE = 0; CondE = 4'b1110;
        FlagWE = 2'b00; ALUFlags = 4'b0000; PCSE = 0;
        RegWE = 0; MemWE = 0; NoWriteE = 0; CntClr = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // ---- vector table ----
    typedef struct {
        int v, st, fl, cond, fwe, alu, pcs, rw, mw, nw, clr;
        int cx, ps, vm, pm, rm, mm, flg, sq;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1,0,0,14,3, 4,0,1,0,0,0, 1,0, 1,0,1,0, 4,0};
        tbl[1]  = '{1,0,0, 0,0, 0,1,0,1,0,0, 1,1, 1,1,0,1, 4,0};
        tbl[2]  = '{1,0,0, 1,3,11,0,1,1,0,0, 0,0, 1,0,0,0, 4,1};
        tbl[3]  = '{1,0,0,14,3, 0,0,1,0,1,0, 1,0, 1,0,0,0, 0,1};
        tbl[4]  = '{1,0,0,14,2,11,0,1,0,0,0, 1,0, 1,0,1,0, 8,1};
        tbl[5]  = '{1,0,0,11,0, 0,1,0,0,0,0, 1,1, 1,1,0,0, 8,1};
        tbl[6]  = '{1,0,0,10,3,15,1,1,1,0,0, 0,0, 1,0,0,0, 8,2};
        tbl[7]  = '{0,0,0,14,3,15,1,1,1,0,0, 0,0, 0,0,0,0, 8,2};
        tbl[8]  = '{1,0,0,15,0, 0,1,0,0,0,0, 0,0, 1,0,0,0, 8,3};
        tbl[9]  = '{1,0,0,15,0, 0,0,0,0,0,1, 0,0, 1,0,0,0, 8,0};
        tbl[10] = '{1,0,1,14,3,15,1,1,1,0,0, 0,0, 0,0,0,0, 8,0};
        tbl[11] = '{1,0,0,12,0, 0,0,0,0,0,0, 0,0, 1,0,0,0, 8,1};
    end

    task automatic cmp_model(string tag);
        chk({tag, ".flags"}, int'(Flags), int'({mn, mz, mc, mv}));
        chk({tag, ".sq"}, int'(SquashCnt), msq);
        chk({tag, ".vm"}, int'(ValidM), int'(mvm));
        chk({tag, ".pm"}, int'(PCSrcM), int'(mpm));
        chk({tag, ".rm"}, int'(RegWriteM), int'(mrm));
        chk({tag, ".mm"}, int'(MemWriteM), int'(mmm));
    endtask

    initial begin
        bit ok;
        reset = 1'b0;
        idle();
        model_reset();
        #12;
        chk("rst.flags", int'(Flags), 0);
        chk("rst.sq", int'(SquashCnt), 0);
        chk("rst.vm", int'(ValidM), 0);
        chk("rst.rm", int'(RegWriteM), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // table-driven vectors from reset state
        foreach (tbl[i]) begin
            ValidE = 1'(tbl[i].v);  StallE = 1'(tbl[i].st);
            FlushE = 1'(tbl[i].fl); CondE = 4'(tbl[i].cond);
            FlagWE = 2'(tbl[i].fwe); ALUFlags = 4'(tbl[i].alu);
            PCSE = 1'(tbl[i].pcs);  RegWE = 1'(tbl[i].rw);
            MemWE = 1'(tbl[i].mw);  NoWriteE = 1'(tbl[i].nw);
            CntClr = 1'(tbl[i].clr);
            #1;
            chk($sformatf("v%0d.cx", i), int'(CondExE), tbl[i].cx);
            chk($sformatf("v%0d.ps", i), int'(PCSrcE), tbl[i].ps);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.vm", i), int'(ValidM), tbl[i].vm);
            chk($sformatf("v%0d.pm", i), int'(PCSrcM), tbl[i].pm);
            chk($sformatf("v%0d.rm", i), int'(RegWriteM), tbl[i].rm);
            chk($sformatf("v%0d.mm", i), int'(MemWriteM), tbl[i].mm);
            chk($sformatf("v%0d.flg", i), int'(Flags), tbl[i].flg);
            chk($sformatf("v%0d.sq", i), int'(SquashCnt), tbl[i].sq);
        end

        // stalled failing instruction: counted once on release
        do_reset();
        ValidE = 1; StallE = 1; CondE = 4'b0000;
        FlagWE = 2'b11; ALUFlags = 4'b1111; RegWE = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d.vm", k), int'(ValidM), 0);
            chk($sformatf("stall%0d.sq", k), int'(SquashCnt), 0);
        end
        StallE = 0;
        @(posedge clk);
        #1;
        chk("release.vm", int'(ValidM), 1);
        chk("release.sq", int'(SquashCnt), 1);
        chk("release.flags", int'(Flags), 0);

        // stall together with flush: bubble, no flag write
        StallE = 1; FlushE = 1; CondE = 4'b1110;
        #1 chk("stfl.cx", int'(CondExE), 0);
        @(posedge clk);
        #1;
        chk("stfl.vm", int'(ValidM), 0);
        chk("stfl.rm", int'(RegWriteM), 0);
        chk("stfl.flags", int'(Flags), 0);
        chk("stfl.sq", int'(SquashCnt), 1);

        // saturation and clear-wins
        do_reset();
        ValidE = 1; CondE = 4'b0000;
        repeat (65535) @(posedge clk);
        #1 chk("sat.pre", int'(SquashCnt), 65535);
        @(posedge clk);
        #1 chk("sat.hold", int'(SquashCnt), 65535);
        CntClr = 1;
        @(posedge clk);
        #1 chk("sat.clr", int'(SquashCnt), 0);

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ValidE   = ($urandom_range(9) != 0);
            StallE   = ($urandom_range(5) == 0);
            FlushE   = ($urandom_range(7) == 0);
            CondE    = 4'($urandom);
            FlagWE   = 2'($urandom);
            ALUFlags = 4'($urandom);
            PCSE     = 1'($urandom);
            RegWE    = 1'($urandom);
            MemWE    = 1'($urandom);
            NoWriteE = 1'($urandom);
            CntClr   = ($urandom_range(40) == 0);
            #1;
            ok = cond_true(CondE, mn, mz, mc, mv);
            chk("rnd.cx", int'(CondExE), int'(ok && ValidE && !FlushE));
            chk("rnd.ps", int'(PCSrcE), int'(ok && ValidE && !FlushE && PCSE));
            @(posedge clk);
            model_edge();
            #1 cmp_model("rnd");
        end

        // async reset mid-operation, no clock edge needed
        idle();
        ValidE = 1; CondE = 4'b1110; FlagWE = 2'b11;
        ALUFlags = 4'b1111; PCSE = 1; RegWE = 1; MemWE = 1;
        @(posedge clk);
        #1 chk("pre.flags", int'(Flags), 15);
        #1 reset = 1'b0;
        #1;
        chk("arst.flags", int'(Flags), 0);
        chk("arst.vm", int'(ValidM), 0);
        chk("arst.pm", int'(PCSrcM), 0);
        chk("arst.rm", int'(RegWriteM), 0);
        chk("arst.mm", int'(MemWriteM), 0);
        chk("arst.sq", int'(SquashCnt), 0);

        // combinational outputs from reset-state flags
        CondE = 4'b0001; FlushE = 0; StallE = 1;
        #1 chk("inrst.cx", int'(CondExE), 1);
        FlushE = 1;
        #1 chk("inrst.cxfl", int'(CondExE), 0);
        FlushE = 0;
        @(posedge clk);
        #1 chk("inrst.flags", int'(Flags), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
